// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding, output buffer depth.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Output buffer depth; also the cap on buffered + in-flight words.
    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;

    // Advance a circular buffer pointer, wrapping at BUF_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/reader_out_buf.sv
// Three-entry circular output buffer holding read data plus its end-of-burst flag.
// Latency: a push is visible on data_o/valid_o the cycle after it is written.
// Backpressure: pop is ignored when empty; the producer must never push when full.
module reader_out_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [PTR_W-1:0]      occupancy_o
);

    logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
    logic                  last_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  pop_ok;

    assign pop_ok      = pop_i && (count_q != '0);
    assign valid_o     = (count_q != '0);
    assign data_o      = data_q[rd_ptr_q];
    assign last_o      = last_q[rd_ptr_q];
    assign occupancy_o = count_q;

    // Pointer and occupancy next-state; push and pop together leave occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the buffer and zeroes the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a len-word burst from an upstream FIFO and replays it as a valid/ready stream with last.
// Latency: first word on m_data two cycles after its read strobe; one word/cycle sustained.
// Backpressure: reads stop once buffered + in-flight words reach 3; m_ready never reaches fifo_rd_en.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    logic [LEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic                   done_q, done_d;

    logic                   rd_en;
    logic                   last_issue;
    logic                   pop;
    logic                   buf_valid;
    logic                   buf_last;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic [PTR_W-1:0]       buf_occ;

    // Read strobe uses only registered state and fifo_empty, keeping m_ready off this path.
    assign last_issue = (issued_q == len_q - LEN_ONE);
    assign rd_en      = (state_q == ST_RUN) && !fifo_empty && (issued_q < len_q)
                        && (({1'b0, buf_occ} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
    assign pop        = buf_valid && m_ready;

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign fifo_rd_en = rd_en;
    assign m_valid    = buf_valid;
    assign m_data     = buf_data;
    assign m_last     = buf_valid && buf_last;

    // Words read last cycle are captured from fifo_dout now, tagged with their end-of-burst flag.
    reader_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .last_o      (buf_last),
        .occupancy_o (buf_occ)
    );

    // Burst sequencing: accept requests in IDLE, issue reads in RUN, wait for the last word in DRAIN.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        issued_d        = issued_q;
        out_cnt_d       = out_cnt_q;
        done_d          = 1'b0;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && last_issue;

        if (pop) begin
            out_cnt_d = out_cnt_q + LEN_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d   = ST_RUN;
                        len_d     = len;
                        issued_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    issued_d = issued_q + LEN_ONE;
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The final word can only be accepted here: it is captured after RUN has ended.
                if (pop && (out_cnt_q == len_q - LEN_ONE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any burst and drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            len_q           <= '0;
            issued_q        <= '0;
            out_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            out_cnt_q       <= out_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural upstream FIFO and an output recorder.
// Latency: n/a.
// Backpressure: m_ready driven directly per step, including a random phase.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          fifo_rd_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    // Upstream FIFO model: contents written by the stimulus, read pointer advanced by reads.
    logic [DW-1:0] mem [0:1023];
    int            wr_cnt = 0;
    int            rd_cnt = 0;

    // Recorder of accepted output words and event counts.
    logic [DW-1:0] got_data [0:1023];
    logic          got_last [0:1023];
    int            got_n      = 0;
    int            rd_total   = 0;
    int            done_total = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] e_rd, e_vld, e_last, e_done, e_busy;

    assign fifo_empty = (rd_cnt == wr_cnt);

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    // FIFO read port: data appears on fifo_dout the cycle after an accepted read.
    always @(posedge clk) begin
        if (fifo_rd_en && (rd_cnt != wr_cnt)) begin
            fifo_dout <= mem[rd_cnt];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // Output recorder.
    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) begin
            got_data[got_n] <= m_data;
            got_last[got_n] <= m_last;
            got_n           <= got_n + 1;
        end
        if (fifo_rd_en) rd_total <= rd_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) mem[wr_cnt + i] = base + DW'(i);
        wr_cnt = wr_cnt + n;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rand_ready);
        int k;
        k = 0;
        while (!done && k < budget) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        check({tag, " done seen"}, 64'(done), 64'd1);
        m_ready = 1'b1;
    endtask

    task automatic check_burst(input string tag, input int g0, input int midx, input int n);
        check({tag, " word count"}, 64'(got_n - g0), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s data%0d", tag, i), 64'(got_data[g0 + i]), 64'(mem[midx + i]));
            check($sformatf("%s last%0d", tag, i), 64'(got_last[g0 + i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        int g0, r0, d0, midx, k;

        rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy",    64'(busy),       64'd0);
        check("reset done",    64'(done),       64'd0);
        check("reset rd_en",   64'(fifo_rd_en), 64'd0);
        check("reset m_valid", 64'(m_valid),    64'd0);
        check("reset m_last",  64'(m_last),     64'd0);
        check("reset m_data",  64'(m_data),     64'd0);
        rst = 1'b0;
        @(negedge clk);

        // len=4, sustained flow: cycle-exact schedule sampled after each rising edge.
        push_words(32'hA0, 4);
        e_rd = 8'b0000_1111; e_vld = 8'b0011_1100; e_last = 8'b0010_0000;
        e_done = 8'b0100_0000; e_busy = 8'b0011_1111;
        d0 = done_total;
        start = 1'b1; len = 8'd4;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("t4 rd_en c%0d", c),   64'(fifo_rd_en), 64'(e_rd[c]));
            check($sformatf("t4 m_valid c%0d", c), 64'(m_valid),    64'(e_vld[c]));
            check($sformatf("t4 m_last c%0d", c),  64'(m_last),     64'(e_last[c]));
            check($sformatf("t4 done c%0d", c),    64'(done),       64'(e_done[c]));
            check($sformatf("t4 busy c%0d", c),    64'(busy),       64'(e_busy[c]));
            if (c >= 2 && c <= 5)
                check($sformatf("t4 m_data c%0d", c), 64'(m_data), 64'(32'hA0 + c - 2));
        end
        check("t4 single done", 64'(done_total - d0), 64'd1);

        // len=0: done pulse only, no reads, never busy.
        r0 = rd_total;
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("t0 done",  64'(done),       64'd1);
        check("t0 busy",  64'(busy),       64'd0);
        check("t0 rd_en", 64'(fifo_rd_en), 64'd0);
        @(negedge clk);
        check("t0 done off", 64'(done), 64'd0);
        check("t0 busy2",    64'(busy), 64'd0);
        check("t0 no reads", 64'(rd_total - r0), 64'd0);

        // len=6 with consumer stalled for 10 cycles: only 3 reads outstanding, data held.
        push_words(32'h100, 6);
        m_ready = 1'b0;
        g0 = got_n; r0 = rd_total; midx = rd_cnt; d0 = done_total;
        start = 1'b1; len = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6 stall valid mid", 64'(m_valid), 64'd1);
        check("t6 stall data mid",  64'(m_data),  64'h100);
        repeat (5) @(negedge clk);
        check("t6 stall reads",     64'(rd_total - r0), 64'd3);
        check("t6 stall valid end", 64'(m_valid),       64'd1);
        check("t6 stall data end",  64'(m_data),        64'h100);
        check("t6 stall rd_en",     64'(fifo_rd_en),    64'd0);
        m_ready = 1'b1;
        wait_done("t6", 200, 1'b0);
        @(negedge clk);
        check_burst("t6", g0, midx, 6);
        check("t6 single done", 64'(done_total - d0), 64'd1);

        // len=5 with only 2 words available; the rest arrive 8 cycles later.
        push_words(32'h200, 2);
        g0 = got_n; r0 = rd_total; midx = rd_cnt; d0 = done_total;
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("t5 reads before refill", 64'(rd_total - r0), 64'd2);
        check("t5 rd_en while empty",   64'(fifo_rd_en),    64'd0);
        check("t5 busy while empty",    64'(busy),          64'd1);
        push_words(32'h202, 3);
        #1;
        check("t5 rd_en resumes", 64'(fifo_rd_en), 64'd1);
        wait_done("t5", 200, 1'b0);
        @(negedge clk);
        check("t5 total reads", 64'(rd_total - r0), 64'd5);
        check_burst("t5", g0, midx, 5);
        check("t5 single done", 64'(done_total - d0), 64'd1);

        // len=8 aborted by reset after the third accepted word.
        push_words(32'h300, 8);
        g0 = got_n;
        start = 1'b1; len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (got_n < g0 + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t8 three accepted", 64'(got_n - g0), 64'd3);
        d0 = done_total;
        rst = 1'b1;
        #1;
        check("t8 rst busy",    64'(busy),       64'd0);
        check("t8 rst done",    64'(done),       64'd0);
        check("t8 rst rd_en",   64'(fifo_rd_en), 64'd0);
        check("t8 rst m_valid", 64'(m_valid),    64'd0);
        check("t8 rst m_last",  64'(m_last),     64'd0);
        check("t8 rst m_data",  64'(m_data),     64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t8 no done after abort", 64'(done_total - d0), 64'd0);
        check("t8 idle after abort",    64'(busy),            64'd0);

        // Normal len=2 burst after the abort: continues from the FIFO's next unread word.
        push_words(32'h400, 2);
        g0 = got_n; midx = rd_cnt; d0 = done_total;
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2", 100, 1'b0);
        @(negedge clk);
        check_burst("t2", g0, midx, 2);
        check("t2 single done", 64'(done_total - d0), 64'd1);

        // len=255 with random consumer backpressure: no counter wrap, one last, one done.
        push_words(32'h1000, 255);
        g0 = got_n; r0 = rd_total; midx = rd_cnt; d0 = done_total;
        start = 1'b1; len = 8'd255;
        @(negedge clk);
        start = 1'b0;
        wait_done("t255", 3000, 1'b1);
        repeat (4) @(negedge clk);
        check("t255 total reads", 64'(rd_total - r0), 64'd255);
        check_burst("t255", g0, midx, 255);
        check("t255 single done", 64'(done_total - d0), 64'd1);
        check("t255 idle at end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
